timer_ctrl: RTL
===============

# timer_ctrl

Button-driven countdown timer controller for the VGA timer display. Consumes single-cycle button pulses (up/down/left/right/centre), lets the user edit a mm:ss preset, then sequences a 1 Hz countdown from a clock prescaler through RUN/PAUSE/DONE. Drives the minute and second values consumed by the on-screen digit renderer, plus field-select and status flags for highlighting.

## Interface
- TICK_CYCLES, 50_000_000: clock cycles per countdown second; legal range ≥ 2.
- i_clk  in  1  system clock; all state changes on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_B_U  in  1  up pulse: increment selected field. One cycle wide, already synchronized and debounced.
- i_B_D  in  1  down pulse: decrement selected field.
- i_B_L  in  1  left pulse: select minutes field.
- i_B_R  in  1  right pulse: select seconds field.
- i_B_C  in  1  centre pulse: start, pause, resume or acknowledge.
- o_min  out  6  current minutes, 0..59.
- o_seg  out  6  current seconds, 0..59.
- o_sel  out  1  selected field: 0 = seconds, 1 = minutes.
- o_state  out  2  state: SET=0, RUN=1, PAUSE=2, DONE=3.
- o_done  out  1  one-cycle pulse on entry to DONE.

## Operation
- **Reset.** Reset clears these to 0 / SET: state = SET, o_min, o_seg, the preset registers (pre_min, pre_seg), o_sel (seconds), prescaler, and o_done.
- **Outputs.** All outputs are registered.
- **Button priority.** When several buttons pulse in the same cycle, only the highest-priority one acts: C > L > R > U > D.

**SET**
- L sets o_sel=1; R sets o_sel=0.
- U increments the selected field modulo 60 (59→0). D decrements it (0→59).
- No carry or borrow passes between the fields.
- C when time ≠ 00:00:
  - pre_min/pre_seg ← o_min/o_seg;
  - prescaler ← 0;
  - go to RUN.
- C when time = 00:00: ignored, state stays SET.

**RUN**
- The prescaler increments every cycle. When it equals TICK_CYCLES-1 it wraps to 0 and a tick fires.
- Tick:
  - if o_seg > 0, o_seg decrements;
  - otherwise o_min decrements and o_seg ← 59.
- If a tick produces 00:00, go to DONE and pulse o_done for that one cycle.
- C: go to PAUSE. The prescaler holds its value.
- U, D, L and R are ignored.

**PAUSE**
- The prescaler and the time are frozen.
- C: go to RUN. The prescaler resumes from its held value.
- L or R: go to SET. Time is kept, the prescaler is cleared, and o_sel updates according to the button.
- U and D are ignored.

**DONE**
- Time stays at 00:00. The prescaler is idle at 0.
- C: o_min/o_seg ← pre_min/pre_seg, then go to SET.
- U, D, L and R are ignored.

**Simultaneous events in RUN**
- Tick and C in the same cycle: the decrement is applied, the prescaler wraps to 0, and the state becomes PAUSE.
- If that same decrement reaches 00:00, DONE takes precedence over PAUSE and o_done pulses.

**Reset mid-operation.** Asserting i_reset_n low in any state returns immediately, asynchronously, to the reset values. The preset is lost.

## Timing
- A button pulse sampled at edge n produces its effect on the outputs visible after edge n (one-cycle latency).
- **Start.** C sampled at edge n gives o_state=RUN and prescaler=0 after edge n. The first decrement is visible after edge n+TICK_CYCLES, and every following decrement comes TICK_CYCLES cycles later.
- **Pause/resume.** Say PAUSE is entered with the prescaler at p. Resume is sampled at edge m. The next decrement is visible after edge m+(TICK_CYCLES-1-p)+1.
- **o_done.** It is high for exactly the one cycle in which o_state first reads DONE. It never re-asserts while the state remains DONE.
- **Max run length.** The maximum preset 59:59 completes in 3599 ticks.

## Test plan
All scenarios use TICK_CYCLES=4.
1. Field editing:
   - Reset, then 3×U → o_seg=3, o_sel=0.
   - 4×D → o_seg=59.
   - L, then 2×U → o_min=2, o_seg=59 unchanged.
2. Zero start: time 00:00, C → o_state stays 0. Then C and U pulsed in the same cycle → only C acts (state still SET, o_seg=0).
3. Countdown to DONE:
   - Preset 00:02, C → o_seg=1 four cycles after RUN entry, then 0 at eight cycles.
   - o_done is high for one cycle and o_state=3.
   - C → SET with 00:02 restored.
4. Borrow: preset 01:00, run one tick → o_min=0, o_seg=59.
5. Pause:
   - Preset 00:05, C; pause with the prescaler at 2; wait 10 cycles → o_seg unchanged at 5.
   - C resumes → decrement to 4 exactly 2 cycles after resume.
   - Then PAUSE, then R → SET with 00:04 kept.
6. Edge cases:
   - Assert i_reset_n low mid-RUN → all outputs 0 and o_state=0 immediately.
   - Separately, C coincident with a tick at 00:01 → o_state=3 (DONE) and o_done pulses.

Source files
------------

// File: rtl/timer_ctrl.sv
// timer_ctrl: button-driven mm:ss countdown controller.
// Edits a preset in SET, counts down at one tick per TICK_CYCLES clocks in RUN,
// can be frozen in PAUSE and reports expiry in DONE. All outputs are registered.
module timer_ctrl #(
    parameter int unsigned TICK_CYCLES = 50_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_B_U,
    input  logic       i_B_D,
    input  logic       i_B_L,
    input  logic       i_B_R,
    input  logic       i_B_C,
    output logic [5:0] o_min,
    output logic [5:0] o_seg,
    output logic       o_sel,
    output logic [1:0] o_state,
    output logic       o_done
);

    localparam int unsigned PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] TickMax = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        StSet   = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StDone  = 3
    } state_e;

    state_e        state_q;
    logic [5:0]    min_q;
    logic [5:0]    seg_q;
    logic [5:0]    pre_min_q;
    logic [5:0]    pre_seg_q;
    logic          sel_q;
    logic [PW-1:0] presc_q;
    logic          done_q;

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] dec60(input logic [5:0] v);
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    // Controller FSM: button handling, prescaler and countdown in one registered block.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= StSet;
            min_q     <= 6'd0;
            seg_q     <= 6'd0;
            pre_min_q <= 6'd0;
            pre_seg_q <= 6'd0;
            sel_q     <= 1'b0;
            presc_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StSet: begin
                    // Priority C > L > R > U > D; a C at 00:00 still masks the others.
                    if (i_B_C) begin
                        if ((min_q != 6'd0) || (seg_q != 6'd0)) begin
                            pre_min_q <= min_q;
                            pre_seg_q <= seg_q;
                            presc_q   <= '0;
                            state_q   <= StRun;
                        end
                    end else if (i_B_L) begin
                        sel_q <= 1'b1;
                    end else if (i_B_R) begin
                        sel_q <= 1'b0;
                    end else if (i_B_U) begin
                        if (sel_q) min_q <= inc60(min_q);
                        else       seg_q <= inc60(seg_q);
                    end else if (i_B_D) begin
                        if (sel_q) min_q <= dec60(min_q);
                        else       seg_q <= dec60(seg_q);
                    end
                end
                StRun: begin
                    if (presc_q == TickMax) begin
                        presc_q <= '0;
                        if (seg_q != 6'd0) begin
                            seg_q <= seg_q - 6'd1;
                        end else begin
                            min_q <= min_q - 6'd1;
                            seg_q <= 6'd59;
                        end
                        // Expiry wins over a coincident pause request.
                        if ((min_q == 6'd0) && (seg_q == 6'd1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else if (i_B_C) begin
                            state_q <= StPause;
                        end
                    end else if (i_B_C) begin
                        // Prescaler holds so resume continues the partial second.
                        state_q <= StPause;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                StPause: begin
                    if (i_B_C) begin
                        state_q <= StRun;
                    end else if (i_B_L) begin
                        sel_q   <= 1'b1;
                        presc_q <= '0;
                        state_q <= StSet;
                    end else if (i_B_R) begin
                        sel_q   <= 1'b0;
                        presc_q <= '0;
                        state_q <= StSet;
                    end
                end
                StDone: begin
                    presc_q <= '0;
                    if (i_B_C) begin
                        min_q   <= pre_min_q;
                        seg_q   <= pre_seg_q;
                        state_q <= StSet;
                    end
                end
            endcase
        end
    end

    assign o_min   = min_q;
    assign o_seg   = seg_q;
    assign o_sel   = sel_q;
    assign o_state = state_q;
    assign o_done  = done_q;

endmodule
